// File: rtl/noc_packetizer.sv
// noc_packetizer
// Network-interface transmit stage feeding a mesh router local input channel.
// Converts an AXI-Stream burst from the core (destination in s_tdest) into NoC
// packets: one header flit carrying target/source coordinates, followed by up
// to MAX_PAYLOAD payload flits. The last flit of every packet has m_tlast set.
// Bursts longer than MAX_PAYLOAD are split into continuation packets, whose
// header has the cont bit set. Bursts addressed outside the mesh are accepted,
// discarded, and reported with a one-cycle drop_pulse.
//
// Header flit layout (LSB first):
//   [X_W-1:0] target x, next Y_W target y, next X_W ROUTER_X,
//   next Y_W ROUTER_Y, next bit cont, all remaining bits zero.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_tdata/s_tdest/s_tlast/s_tvalid/s_tready   core-side AXI-Stream slave
//   m_tdata/m_tdest/m_tlast/m_tvalid/m_tready   router-side flit stream (registered)
//   drop_pulse        one-cycle pulse when a dropped burst completes
//
// Optional build macro NOC_PKT_STATS_EN adds pkt_count, flit_count and
// drop_count statistics outputs.
module noc_packetizer #(
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_ROUTERS_X           = 4,
    parameter int MAX_ROUTERS_Y           = 4,
    parameter int ROUTER_X                = 0,
    parameter int ROUTER_Y                = 0,
    parameter int MAXIMUM_PACKAGES_NUMBER = 5,
    parameter int MAX_PAYLOAD             = MAXIMUM_PACKAGES_NUMBER - 1,
    localparam int X_W = $clog2(MAX_ROUTERS_X),
    localparam int Y_W = $clog2(MAX_ROUTERS_Y)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [X_W+Y_W-1:0]    s_tdest,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [X_W+Y_W-1:0]    m_tdest,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  drop_pulse
`ifdef NOC_PKT_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           flit_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int CW = (MAX_PAYLOAD < 2) ? 1 : $clog2(MAX_PAYLOAD + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(MAX_PAYLOAD - 1);
    localparam logic [X_W:0]   LIM_X    = (X_W + 1)'(MAX_ROUTERS_X);
    localparam logic [Y_W:0]   LIM_Y    = (Y_W + 1)'(MAX_ROUTERS_Y);
    localparam logic [X_W-1:0] SRC_X    = X_W'(ROUTER_X);
    localparam logic [Y_W-1:0] SRC_Y    = Y_W'(ROUTER_Y);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]            state;
    logic [X_W+Y_W-1:0]    dest_r;
    logic                  cont;
    logic [CW-1:0]         flit_cnt;
    logic                  can_load;
    logic                  s_hs;
    logic                  seg_end;
    logic                  dest_ok;
    logic [DATA_WIDTH-1:0] hdr_flit;

    // Output register is free when empty or being drained this cycle.
    assign can_load = !m_tvalid || m_tready;
    assign s_hs     = s_tvalid && s_tready;
    assign seg_end  = (flit_cnt == LAST_CNT);
    assign dest_ok  = ({1'b0, s_tdest[X_W-1:0]} < LIM_X) &&
                      ({1'b0, s_tdest[X_W+Y_W-1:X_W]} < LIM_Y);

    always_comb begin
        s_tready = 1'b0;
        case (state)
            ST_PAY:  s_tready = can_load;
            ST_DROP: s_tready = 1'b1;
            default: s_tready = 1'b0;
        endcase
    end

    always_comb begin
        hdr_flit = '0;
        hdr_flit[X_W+Y_W-1:0]       = dest_r;
        hdr_flit[X_W+Y_W +: X_W]    = SRC_X;
        hdr_flit[2*X_W+Y_W +: Y_W]  = SRC_Y;
        hdr_flit[2*(X_W+Y_W)]       = cont;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dest_r     <= '0;
            cont       <= 1'b0;
            flit_cnt   <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tdest    <= '0;
            m_tlast    <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            // A consumed flit empties the register unless reloaded below.
            if (m_tready)
                m_tvalid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (s_tvalid) begin
                        if (dest_ok) begin
                            dest_r <= s_tdest;
                            cont   <= 1'b0;
                            state  <= ST_HDR;
                        end else begin
                            state  <= ST_DROP;
                        end
                    end
                end
                ST_HDR: begin
                    if (can_load) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= hdr_flit;
                        m_tdest  <= dest_r;
                        m_tlast  <= 1'b0;
                        flit_cnt <= '0;
                        state    <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (s_hs) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= s_tdata;
                        m_tlast  <= s_tlast || seg_end;
                        flit_cnt <= flit_cnt + CW'(1);
                        if (s_tlast) begin
                            state <= ST_IDLE;
                        end else if (seg_end) begin
                            cont  <= 1'b1;
                            state <= ST_HDR;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_tvalid && s_tlast) begin
                        drop_pulse <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NOC_PKT_STATS_EN
    // Tracks whether the flit currently held in the output register is a header.
    logic out_hdr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hdr    <= 1'b0;
            pkt_count  <= '0;
            flit_count <= '0;
            drop_count <= '0;
        end else begin
            if (state == ST_HDR && can_load)
                out_hdr <= 1'b1;
            else if (state == ST_PAY && s_hs)
                out_hdr <= 1'b0;
            if (m_tvalid && m_tready) begin
                flit_count <= flit_count + 32'd1;
                if (out_hdr)
                    pkt_count <= pkt_count + 32'd1;
            end
            if (drop_pulse)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
module tb_noc_packetizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] s_tdata, m_tdata, s2_tdata, m2_tdata;
    logic [3:0]  s_tdest, m_tdest, s2_tdest, m2_tdest;
    logic        s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready, drop_pulse;
    logic        s2_tlast, s2_tvalid, s2_tready, m2_tlast, m2_tvalid, m2_tready, drop_pulse2;
`ifdef NOC_PKT_STATS_EN
    logic [31:0] pkt_count, flit_count, pkt_count2, flit_count2;
    logic [15:0] drop_count, drop_count2;
`endif

    noc_packetizer #(.ROUTER_X(1), .ROUTER_Y(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tdest(s_tdest), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .drop_pulse(drop_pulse)
`ifdef NOC_PKT_STATS_EN
        , .pkt_count(pkt_count), .flit_count(flit_count), .drop_count(drop_count)
`endif
    );

    noc_packetizer #(.MAX_ROUTERS_X(3), .ROUTER_X(1), .ROUTER_Y(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s2_tdata), .s_tdest(s2_tdest), .s_tlast(s2_tlast),
        .s_tvalid(s2_tvalid), .s_tready(s2_tready),
        .m_tdata(m2_tdata), .m_tdest(m2_tdest), .m_tlast(m2_tlast),
        .m_tvalid(m2_tvalid), .m_tready(m2_tready), .drop_pulse(drop_pulse2)
`ifdef NOC_PKT_STATS_EN
        , .pkt_count(pkt_count2), .flit_count(flit_count2), .drop_count(drop_count2)
`endif
    );

    int tests = 0;
    int fails = 0;
    int m2_valid_cycles = 0;
    int stall_checks = 0;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flits handed over to the router: {tlast, tdest, tdata}.
    always @(posedge clk)
        if (rst_n && m_tvalid && m_tready)
            got_q.push_back({m_tlast, m_tdest, m_tdata});

    always @(posedge clk)
        if (rst_n && m2_tvalid)
            m2_valid_cycles++;

    // Stall driver: applies a ready pattern and checks the output holds while stalled.
    bit          stall_en = 1'b0;
    int          stall_idx;
    bit          prev_stall;
    logic [36:0] held;
    logic [7:0]  stall_pat = 8'b1010_0111; // index 0 is LSB: 1,1,1,0,0,1,0,1

    always @(negedge clk) begin
        if (stall_en) begin
            if (prev_stall) begin
                stall_checks++;
                check("stall_hold", {m_tlast, m_tdest, m_tdata}, held);
            end
            held = {m_tlast, m_tdest, m_tdata};
            m_tready = (stall_idx < 8) ? stall_pat[stall_idx] : 1'b1;
            stall_idx++;
            prev_stall = m_tvalid && !m_tready;
        end
    end

    task automatic send(input bit sel, input logic [31:0] d, input logic [3:0] dst,
                        input bit last, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        if (sel) begin
            s2_tdata = d; s2_tdest = dst; s2_tlast = last; s2_tvalid = 1'b1;
        end else begin
            s_tdata = d; s_tdest = dst; s_tlast = last; s_tvalid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            #1;
            if (sel ? s2_tready : s_tready) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (ok)
            @(posedge clk);
        else begin
            tests++;
            fails++;
            $error("FAIL send_timeout: observed no s_tready expected s_tready within 50 cycles");
        end
        @(negedge clk);
        if (sel) s2_tvalid = 1'b0;
        else     s_tvalid  = 1'b0;
    endtask

    task automatic burst(input logic [3:0] dst, input logic [31:0] base, input int n);
        int w;
        for (int i = 0; i < n; i++)
            send(1'b0, base + 32'(i), dst, (i == n - 1), w);
    endtask

    task automatic exp_flit(input bit last, input logic [3:0] dst, input logic [31:0] d);
        exp_q.push_back({last, dst, d});
    endtask

    task automatic compare_flits(input string tag);
        int n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_flit%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w1, w2;
        rst_n = 1'b0;
        s_tdata = '0;  s_tdest = '0;  s_tlast = 1'b0;  s_tvalid = 1'b0;
        s2_tdata = '0; s2_tdest = '0; s2_tlast = 1'b0; s2_tvalid = 1'b0;
        m_tready = 1'b1;
        m2_tready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tdest", m_tdest, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3-beat burst to x=2,y=3 from (1,2)
        burst(4'hE, 32'hA1, 3);
        repeat (4) @(negedge clk);
        exp_flit(0, 4'hE, 32'h0000009E);
        exp_flit(0, 4'hE, 32'hA1);
        exp_flit(0, 4'hE, 32'hA2);
        exp_flit(1, 4'hE, 32'hA3);
        compare_flits("b3");

        // 9-beat burst: 4+4+1 payload, continuation headers
        burst(4'h5, 32'h100, 9);
        repeat (4) @(negedge clk);
        exp_flit(0, 4'h5, 32'h095);
        for (int i = 0; i < 4; i++) exp_flit(i == 3, 4'h5, 32'h100 + 32'(i));
        exp_flit(0, 4'h5, 32'h195);
        for (int i = 4; i < 8; i++) exp_flit(i == 7, 4'h5, 32'h100 + 32'(i));
        exp_flit(0, 4'h5, 32'h195);
        exp_flit(1, 4'h5, 32'h108);
        compare_flits("b9");

        // Exactly MAX_PAYLOAD beats: no continuation header
        burst(4'h0, 32'hC1, 4);
        repeat (6) @(negedge clk);
        exp_flit(0, 4'h0, 32'h090);
        exp_flit(0, 4'h0, 32'hC1);
        exp_flit(0, 4'h0, 32'hC2);
        exp_flit(0, 4'h0, 32'hC3);
        exp_flit(1, 4'h0, 32'hC4);
        compare_flits("b4");

        // Backpressure: output held while stalled, sequence unchanged
        stall_idx = 0;
        prev_stall = 1'b0;
        stall_en = 1'b1;
        burst(4'h5, 32'hD1, 4);
        repeat (6) @(negedge clk);
        stall_en = 1'b0;
        m_tready = 1'b1;
        exp_flit(0, 4'h5, 32'h095);
        for (int i = 0; i < 4; i++) exp_flit(i == 3, 4'h5, 32'hD1 + 32'(i));
        compare_flits("stall");
        check("stall_seen", 64'(stall_checks > 0), 1);

        // Out-of-mesh destination (x=3 with 3 columns) is drained and dropped
        send(1'b1, 32'hF1, 4'h3, 1'b0, w1);
        send(1'b1, 32'hF2, 4'h3, 1'b1, w2);
        check("drop_beat2_waits", 64'(w2), 0);
        check("drop_pulse_hi", drop_pulse2, 1);
`ifdef NOC_PKT_STATS_EN
        check("drop_count", drop_count2, 1);
`endif
        @(negedge clk);
        check("drop_pulse_lo", drop_pulse2, 0);
        check("drop_no_mvalid", 64'(m2_valid_cycles), 0);

        // Reset mid-packet after header and one payload flit
        send(1'b0, 32'h71, 4'h5, 1'b0, w1);
        @(negedge clk);
        exp_flit(0, 4'h5, 32'h095);
        exp_flit(0, 4'h5, 32'h71);
        compare_flits("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_m_tvalid", m_tvalid, 0);
        check("async_rst_m_tdata", m_tdata, 0);
        check("async_rst_s_tready", s_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        burst(4'h5, 32'hE1, 1);
        repeat (4) @(negedge clk);
        exp_flit(0, 4'h5, 32'h095);
        exp_flit(1, 4'h5, 32'hE1);
        compare_flits("post_rst");
`ifdef NOC_PKT_STATS_EN
        check("pkt_count", pkt_count, 1);
        check("flit_count", flit_count, 2);
        check("drop_count_main", drop_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
